// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter: ibus and dbus share one memory AR/R port.
// One burst is in flight at a time; R beats are routed to the owner and rlast is checked.
module axi_read_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] ibus_araddr_i,
    input  logic [7:0]            ibus_arlen_i,
    input  logic [2:0]            ibus_arsize_i,
    input  logic [1:0]            ibus_arburst_i,
    input  logic                  ibus_arvalid_i,
    output logic                  ibus_arready_o,
    output logic [DATA_WIDTH-1:0] ibus_rdata_o,
    output logic [1:0]            ibus_rresp_o,
    output logic                  ibus_rlast_o,
    output logic                  ibus_rvalid_o,
    input  logic                  ibus_rready_i,
    input  logic [ADDR_WIDTH-1:0] dbus_araddr_i,
    input  logic [7:0]            dbus_arlen_i,
    input  logic [2:0]            dbus_arsize_i,
    input  logic [1:0]            dbus_arburst_i,
    input  logic                  dbus_arvalid_i,
    output logic                  dbus_arready_o,
    output logic [DATA_WIDTH-1:0] dbus_rdata_o,
    output logic [1:0]            dbus_rresp_o,
    output logic                  dbus_rlast_o,
    output logic                  dbus_rvalid_o,
    input  logic                  dbus_rready_i,
    output logic [ADDR_WIDTH-1:0] m_araddr_o,
    output logic [7:0]            m_arlen_o,
    output logic [2:0]            m_arsize_o,
    output logic [1:0]            m_arburst_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic                  m_rlast_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic                  grant_dbus_o,
    output logic                  busy_o,
    output logic                  len_err_o
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  arvalid_q, arvalid_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [7:0]            beat_q, beat_d;
    logic                  len_err_q, len_err_d;
    logic                  sel_dbus;
    logic                  rready_sel;

    always_comb begin
        state_d        = state_q;
        araddr_d       = araddr_q;
        arlen_d        = arlen_q;
        arsize_d       = arsize_q;
        arburst_d      = arburst_q;
        arvalid_d      = arvalid_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        beat_d         = beat_q;
        len_err_d      = len_err_q;
        ibus_arready_o = 1'b0;
        dbus_arready_o = 1'b0;
        ibus_rdata_o   = '0;
        ibus_rresp_o   = '0;
        ibus_rlast_o   = 1'b0;
        ibus_rvalid_o  = 1'b0;
        dbus_rdata_o   = '0;
        dbus_rresp_o   = '0;
        dbus_rlast_o   = 1'b0;
        dbus_rvalid_o  = 1'b0;
        rready_sel     = 1'b0;
        // Tie goes to the non-last owner in round-robin mode, to ibus in fixed mode.
        sel_dbus = dbus_arvalid_i &&
                   (!ibus_arvalid_i || (PRIORITY_MODE == 0 && !last_grant_q));

        unique case (state_q)
            StIdle: begin
                // Gated by reset so arready reads 0 while reset is held.
                if (rst_ni && (ibus_arvalid_i || dbus_arvalid_i)) begin
                    ibus_arready_o = !sel_dbus;
                    dbus_arready_o = sel_dbus;
                    araddr_d       = sel_dbus ? dbus_araddr_i  : ibus_araddr_i;
                    arlen_d        = sel_dbus ? dbus_arlen_i   : ibus_arlen_i;
                    arsize_d       = sel_dbus ? dbus_arsize_i  : ibus_arsize_i;
                    arburst_d      = sel_dbus ? dbus_arburst_i : ibus_arburst_i;
                    grant_d        = sel_dbus;
                    arvalid_d      = 1'b1;
                    state_d        = StAddr;
                end
            end
            StAddr: begin
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    beat_d    = 8'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (grant_q) begin
                    dbus_rdata_o  = m_rdata_i;
                    dbus_rresp_o  = m_rresp_i;
                    dbus_rlast_o  = m_rlast_i;
                    dbus_rvalid_o = m_rvalid_i;
                    rready_sel    = dbus_rready_i;
                end else begin
                    ibus_rdata_o  = m_rdata_i;
                    ibus_rresp_o  = m_rresp_i;
                    ibus_rlast_o  = m_rlast_i;
                    ibus_rvalid_o = m_rvalid_i;
                    rready_sel    = ibus_rready_i;
                end
                if (m_rvalid_i && rready_sel) begin
                    beat_d = beat_q + 8'd1;
                    // rlast must coincide exactly with beat index == arlen.
                    if (m_rlast_i != (beat_q == arlen_q)) begin
                        len_err_d = 1'b1;
                    end
                    if (m_rlast_i) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arvalid_q    <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            arvalid_q    <= arvalid_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            len_err_q    <= len_err_d;
        end
    end

    assign m_araddr_o   = araddr_q;
    assign m_arlen_o    = arlen_q;
    assign m_arsize_o   = arsize_q;
    assign m_arburst_o  = arburst_q;
    assign m_arvalid_o  = arvalid_q;
    assign m_rready_o   = rready_sel;
    assign grant_dbus_o = grant_q;
    assign busy_o       = (state_q != StIdle);
    assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: round-robin instance plus a fixed-priority instance.
module tb_axi_read_arbiter;

    logic clk, rst_n;

    logic [31:0] i_araddr, d_araddr, m_araddr, m_rdata;
    logic [7:0]  i_arlen, d_arlen, m_arlen;
    logic [2:0]  i_arsize, d_arsize, m_arsize;
    logic [1:0]  i_arburst, d_arburst, m_arburst, m_rresp;
    logic        i_arvalid, i_arready, i_rready, i_rvalid, i_rlast;
    logic        d_arvalid, d_arready, d_rready, d_rvalid, d_rlast;
    logic [31:0] i_rdata, d_rdata;
    logic [1:0]  i_rresp, d_rresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        grant_d, busy, len_err;

    // Fixed-priority instance: own handshakes, shares field inputs.
    logic        p_iv, p_ir, p_irr, p_irv, p_irl, p_dv, p_dr, p_drr, p_drv, p_drl;
    logic [31:0] p_ird, p_drd, p_maddr;
    logic [1:0]  p_irs, p_drs, p_mburst;
    logic [7:0]  p_mlen;
    logic [2:0]  p_msize;
    logic        p_marv, p_marr, p_mrv, p_mrl, p_mrr, p_grant, p_busy, p_lerr;

    int checks = 0;
    int errors = 0;

    axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .ibus_araddr_i(i_araddr), .ibus_arlen_i(i_arlen), .ibus_arsize_i(i_arsize),
        .ibus_arburst_i(i_arburst), .ibus_arvalid_i(i_arvalid), .ibus_arready_o(i_arready),
        .ibus_rdata_o(i_rdata), .ibus_rresp_o(i_rresp), .ibus_rlast_o(i_rlast),
        .ibus_rvalid_o(i_rvalid), .ibus_rready_i(i_rready),
        .dbus_araddr_i(d_araddr), .dbus_arlen_i(d_arlen), .dbus_arsize_i(d_arsize),
        .dbus_arburst_i(d_arburst), .dbus_arvalid_i(d_arvalid), .dbus_arready_o(d_arready),
        .dbus_rdata_o(d_rdata), .dbus_rresp_o(d_rresp), .dbus_rlast_o(d_rlast),
        .dbus_rvalid_o(d_rvalid), .dbus_rready_i(d_rready),
        .m_araddr_o(m_araddr), .m_arlen_o(m_arlen), .m_arsize_o(m_arsize),
        .m_arburst_o(m_arburst), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
        .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rlast_i(m_rlast),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
        .grant_dbus_o(grant_d), .busy_o(busy), .len_err_o(len_err)
    );

    axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .ibus_araddr_i(i_araddr), .ibus_arlen_i(i_arlen), .ibus_arsize_i(i_arsize),
        .ibus_arburst_i(i_arburst), .ibus_arvalid_i(p_iv), .ibus_arready_o(p_ir),
        .ibus_rdata_o(p_ird), .ibus_rresp_o(p_irs), .ibus_rlast_o(p_irl),
        .ibus_rvalid_o(p_irv), .ibus_rready_i(p_irr),
        .dbus_araddr_i(d_araddr), .dbus_arlen_i(d_arlen), .dbus_arsize_i(d_arsize),
        .dbus_arburst_i(d_arburst), .dbus_arvalid_i(p_dv), .dbus_arready_o(p_dr),
        .dbus_rdata_o(p_drd), .dbus_rresp_o(p_drs), .dbus_rlast_o(p_drl),
        .dbus_rvalid_o(p_drv), .dbus_rready_i(p_drr),
        .m_araddr_o(p_maddr), .m_arlen_o(p_mlen), .m_arsize_o(p_msize),
        .m_arburst_o(p_mburst), .m_arvalid_o(p_marv), .m_arready_i(p_marr),
        .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rlast_i(p_mrl),
        .m_rvalid_i(p_mrv), .m_rready_o(p_mrr),
        .grant_dbus_o(p_grant), .busy_o(p_busy), .len_err_o(p_lerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iv;
        logic dv;
        logic exp_ir;
        logic exp_dr;
    } arb_vec_t;

    arb_vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge with the requester inputs already driven; leaves at a negedge in DATA.
    task automatic ar_phase(input logic exp_d, input logic [31:0] exp_addr,
                            input logic [7:0] exp_len);
        #1;
        chk("arready_i", 32'(i_arready), 32'(!exp_d));
        chk("arready_d", 32'(d_arready), 32'(exp_d));
        @(negedge clk);
        if (exp_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
        m_arready = 1'b0;
        #1;
        chk("m_arvalid", 32'(m_arvalid), 32'd1);
        chk("m_araddr", m_araddr, exp_addr);
        chk("m_arlen", 32'(m_arlen), 32'(exp_len));
        chk("m_arsize", 32'(m_arsize), exp_d ? 32'd1 : 32'd2);
        chk("m_arburst", 32'(m_arburst), exp_d ? 32'd2 : 32'd1);
        chk("grant", 32'(grant_d), 32'(exp_d));
        chk("busy_addr", 32'(busy), 32'd1);
        chk("arready_addr", 32'({i_arready, d_arready}), 32'd0);
        @(negedge clk);
        m_arready = 1'b1;
        #1;
        chk("m_ar_hold", m_araddr, exp_addr);
        @(negedge clk);
        m_arready = 1'b0;
        chk("m_arvalid_drop", 32'(m_arvalid), 32'd0);
    endtask

    // Memory model streams nbeats (rlast on the final one), with optional gaps/back-pressure.
    task automatic data_phase(input logic exp_d, input int nbeats, input logic gaps,
                              input logic stalls);
        int b = 0;
        int cyc = 0;
        logic mv, rr;
        while (b < nbeats && cyc < 200) begin
            mv = !(gaps && (cyc % 3 == 1));
            rr = !(stalls && (cyc % 4 == 2));
            m_rvalid = mv;
            m_rdata = 32'hC0DE_0000 + 32'(b);
            m_rresp = 2'(b);
            m_rlast = (b == nbeats - 1);
            if (exp_d) begin d_rready = rr; i_rready = 1'b1; end
            else begin i_rready = rr; d_rready = 1'b1; end
            #1;
            chk("own_rvalid", 32'(exp_d ? d_rvalid : i_rvalid), 32'(mv));
            chk("other_rvalid", 32'(exp_d ? i_rvalid : d_rvalid), 32'd0);
            chk("m_rready", 32'(m_rready), 32'(rr));
            chk("arready_data", 32'({i_arready, d_arready}), 32'd0);
            if (mv) begin
                chk("rdata", exp_d ? d_rdata : i_rdata, 32'hC0DE_0000 + 32'(b));
                chk("rresp", 32'(exp_d ? d_rresp : i_rresp), 32'(b % 4));
                chk("rlast", 32'(exp_d ? d_rlast : i_rlast), 32'(b == nbeats - 1));
            end
            if (mv && rr) b++;
            cyc++;
            @(negedge clk);
        end
        if (b != nbeats) chk("beat_timeout", 32'(b), 32'(nbeats));
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
    endtask

    task automatic idle_chk(input logic exp_err);
        #1;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("len_err", 32'(len_err), 32'(exp_err));
    endtask

    task automatic set_i(input logic [31:0] a, input logic [7:0] l);
        i_araddr = a; i_arlen = l; i_arvalid = 1'b1;
    endtask

    task automatic set_d(input logic [31:0] a, input logic [7:0] l);
        d_araddr = a; d_arlen = l; d_arvalid = 1'b1;
    endtask

    initial begin
        vecs[0] = '{iv: 1'b0, dv: 1'b0, exp_ir: 1'b0, exp_dr: 1'b0};
        vecs[1] = '{iv: 1'b1, dv: 1'b0, exp_ir: 1'b1, exp_dr: 1'b0};
        vecs[2] = '{iv: 1'b0, dv: 1'b1, exp_ir: 1'b0, exp_dr: 1'b1};
        vecs[3] = '{iv: 1'b1, dv: 1'b1, exp_ir: 1'b1, exp_dr: 1'b0};

        rst_n = 1'b0;
        i_araddr = '0; i_arlen = '0; i_arsize = 3'd2; i_arburst = 2'd1; i_arvalid = 1'b0;
        d_araddr = '0; d_arlen = '0; d_arsize = 3'd1; d_arburst = 2'd2; d_arvalid = 1'b0;
        i_rready = 1'b0; d_rready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        p_iv = 1'b0; p_dv = 1'b0; p_irr = 1'b0; p_drr = 1'b0;
        p_marr = 1'b0; p_mrv = 1'b0; p_mrl = 1'b0;
        #1;
        chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_m_araddr", m_araddr, 32'd0);
        chk("rst_grant", 32'(grant_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_m_rready", 32'(m_rready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Combinational arbitration straight after reset (inputs withdrawn before the edge).
        foreach (vecs[k]) begin
            i_arvalid = vecs[k].iv;
            d_arvalid = vecs[k].dv;
            #1;
            chk("tbl_arready_i", 32'(i_arready), 32'(vecs[k].exp_ir));
            chk("tbl_arready_d", 32'(d_arready), 32'(vecs[k].exp_dr));
            i_arvalid = 1'b0;
            d_arvalid = 1'b0;
            @(negedge clk);
        end
        chk("tbl_still_idle", 32'(busy), 32'd0);

        // Simultaneous pair after reset: ibus then dbus, twice.
        set_i(32'h200, 8'd1); set_d(32'h300, 8'd0);
        ar_phase(1'b0, 32'h200, 8'd1);
        data_phase(1'b0, 2, 1'b0, 1'b0);
        ar_phase(1'b1, 32'h300, 8'd0);
        data_phase(1'b1, 1, 1'b0, 1'b0);
        idle_chk(1'b0);
        set_i(32'h240, 8'd0); set_d(32'h340, 8'd2);
        ar_phase(1'b0, 32'h240, 8'd0);
        data_phase(1'b0, 1, 1'b0, 1'b0);
        ar_phase(1'b1, 32'h340, 8'd2);
        data_phase(1'b1, 3, 1'b0, 1'b0);
        idle_chk(1'b0);

        // Single ibus burst, 4 beats.
        set_i(32'h100, 8'd3);
        ar_phase(1'b0, 32'h100, 8'd3);
        data_phase(1'b0, 4, 1'b0, 1'b0);
        idle_chk(1'b0);

        // Last owner was ibus, so a tie now goes to dbus.
        set_i(32'h400, 8'd0); set_d(32'h500, 8'd0);
        ar_phase(1'b1, 32'h500, 8'd0);
        data_phase(1'b1, 1, 1'b0, 1'b0);
        ar_phase(1'b0, 32'h400, 8'd0);
        data_phase(1'b0, 1, 1'b0, 1'b0);
        idle_chk(1'b0);

        // dbus waits through an ibus burst with gaps and back-pressure.
        set_i(32'h600, 8'd3);
        ar_phase(1'b0, 32'h600, 8'd3);
        set_d(32'h680, 8'd1);
        data_phase(1'b0, 4, 1'b1, 1'b1);
        ar_phase(1'b1, 32'h680, 8'd1);
        data_phase(1'b1, 2, 1'b1, 1'b0);
        idle_chk(1'b0);

        // Early rlast sets the sticky error; a correct burst afterwards still completes.
        set_i(32'h800, 8'd3);
        ar_phase(1'b0, 32'h800, 8'd3);
        data_phase(1'b0, 3, 1'b0, 1'b0);
        idle_chk(1'b1);
        set_i(32'h840, 8'd1);
        ar_phase(1'b0, 32'h840, 8'd1);
        data_phase(1'b0, 2, 1'b0, 1'b0);
        idle_chk(1'b1);

        // Reset in the middle of beat 1.
        set_i(32'h900, 8'd3);
        ar_phase(1'b0, 32'h900, 8'd3);
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'hAAAA_0000; i_rready = 1'b1;
        @(negedge clk);
        m_rdata = 32'hAAAA_0001;
        #1;
        chk("pre_rst_rvalid", 32'(i_rvalid), 32'd1);
        rst_n = 1'b0;
        i_arvalid = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(i_rvalid), 32'd0);
        chk("mid_rst_m_rready", 32'(m_rready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_m_arvalid", 32'(m_arvalid), 32'd0);
        chk("mid_rst_m_araddr", m_araddr, 32'd0);
        chk("mid_rst_grant", 32'(grant_d), 32'd0);
        chk("mid_rst_len_err", 32'(len_err), 32'd0);
        chk("mid_rst_arready", 32'(i_arready), 32'd0);
        m_rvalid = 1'b0;
        i_arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Missing rlast when beat index reaches arlen is also an error.
        set_i(32'h940, 8'd0);
        ar_phase(1'b0, 32'h940, 8'd0);
        data_phase(1'b0, 2, 1'b0, 1'b0);
        idle_chk(1'b1);

        // Fixed priority: ibus re-requests every IDLE while dbus waits.
        p_dv = 1'b1;
        for (int n = 0; n < 4; n++) begin
            p_iv = 1'b1;
            #1;
            chk("fp_arready_i", 32'(p_ir), 32'd1);
            chk("fp_arready_d", 32'(p_dr), 32'd0);
            @(negedge clk);
            p_iv = 1'b0;
            p_marr = 1'b1;
            #1;
            chk("fp_grant", 32'(p_grant), 32'd0);
            chk("fp_m_arvalid", 32'(p_marv), 32'd1);
            @(negedge clk);
            p_marr = 1'b0;
            p_mrv = 1'b1; p_mrl = 1'b1; p_irr = 1'b1;
            #1;
            chk("fp_rvalid_i", 32'(p_irv), 32'd1);
            chk("fp_rvalid_d", 32'(p_drv), 32'd0);
            @(negedge clk);
            p_mrv = 1'b0; p_mrl = 1'b0;
        end
        #1;
        chk("fp_dbus_alone", 32'(p_dr), 32'd1);
        p_dv = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
